// File: rtl/signed_minmax_tracker.sv
// Streaming signed min/max reduction stage.
// Consumes one packet of two's-complement samples over a valid/ready stream,
// tracks the running minimum and maximum together with the index of their
// first occurrence, and presents a single held result beat after the last
// sample. The sample count saturates at 2^CNT_W-1 and flags the overflow.
module signed_minmax_tracker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [CNT_W-1:0] min_idx_q;
    logic [CNT_W-1:0] max_idx_q;
    logic [CNT_W-1:0] count_q;
    logic             sat_q;

    logic             in_xfer;
    logic             new_min;
    logic             new_max;
    logic             cnt_full;

    // A sample moves only on a handshake; ready is a register, so there is
    // no combinational path from out_ready back to in_ready.
    assign in_xfer  = in_valid & in_ready;

    // Strict signed compares: equal values never displace the earlier index.
    assign new_min  = $signed(in_data) < $signed(min_q);
    assign new_max  = $signed(max_q) < $signed(in_data);

    // Once the count pins at its maximum, it doubles as the saturated index.
    assign cnt_full = (count_q == CNT_MAX);

    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
    assign out_count   = count_q;
    assign out_sat     = sat_q;

    // Packet FSM: seed on the first beat, fold in later beats, then hold the
    // result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        min_q     <= in_data;
                        max_q     <= in_data;
                        min_idx_q <= '0;
                        max_idx_q <= '0;
                        count_q   <= CNT_W'(1);
                        sat_q     <= 1'b0;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        if (new_min) begin
                            min_q     <= in_data;
                            min_idx_q <= count_q;
                        end
                        if (new_max) begin
                            max_q     <= in_data;
                            max_idx_q <= count_q;
                        end
                        if (cnt_full) begin
                            sat_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Testbench for signed_minmax_tracker.
// Two instances: a full-width one (CNT_W = 16) and a narrow-count one
// (CNT_W = 4) so saturation is reachable with short packets. A packet-level
// reference model computes the expected result from the accepted samples
// and is compared against the DUT outputs every cycle.
module tb_signed_minmax_tracker;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        inValid [2];
    logic        inLast  [2];
    logic        outReady[2];
    logic [31:0] inData  [2];

    logic        aInReady, aOutValid, aSat;
    logic [31:0] aMin, aMax;
    logic [15:0] aMinIdx, aMaxIdx, aCount;

    logic        bInReady, bOutValid, bSat;
    logic [31:0] bMin, bMax;
    logic [3:0]  bMinIdx, bMaxIdx, bCount;

    int          checkCount = 0;
    int          passCount  = 0;

    // Reference model state: samples of the packet in flight and the result
    // that must be presented once the packet has closed.
    logic [31:0] pkt [2][0:255];
    int          pktLen   [2];
    int          maxCnt   [2];
    logic        expActive[2];
    logic [31:0] expMin   [2];
    logic [31:0] expMax   [2];
    int          expMinIdx[2];
    int          expMaxIdx[2];
    int          expCount [2];
    logic        expSat   [2];

    logic [31:0] vec [0:127];

    signed_minmax_tracker #(.WIDTH(32), .CNT_W(16)) dutA (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid[0]),
        .in_ready   (aInReady),
        .in_data    (inData[0]),
        .in_last    (inLast[0]),
        .out_valid  (aOutValid),
        .out_ready  (outReady[0]),
        .out_min    (aMin),
        .out_max    (aMax),
        .out_min_idx(aMinIdx),
        .out_max_idx(aMaxIdx),
        .out_count  (aCount),
        .out_sat    (aSat)
    );

    signed_minmax_tracker #(.WIDTH(32), .CNT_W(4)) dutB (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid[1]),
        .in_ready   (bInReady),
        .in_data    (inData[1]),
        .in_last    (inLast[1]),
        .out_valid  (bOutValid),
        .out_ready  (outReady[1]),
        .out_min    (bMin),
        .out_max    (bMax),
        .out_min_idx(bMinIdx),
        .out_max_idx(bMaxIdx),
        .out_count  (bCount),
        .out_sat    (bSat)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checkCount++;
        $display("[TB] FAIL %s: got timeout, expected handshake", name);
    endtask

    // Packet-level reference: min/max are the extremes of the sample set,
    // indices are the first position holding that value, clamped to the
    // largest representable count.
    function automatic void modelResult(input int d);
        int          n;
        int          fm;
        int          fx;
        logic [31:0] mn;
        logic [31:0] mx;
        n  = pktLen[d];
        mn = pkt[d][0];
        mx = pkt[d][0];
        for (int j = 1; j < n; j++) begin
            if ($signed(pkt[d][j]) < $signed(mn)) mn = pkt[d][j];
            if ($signed(pkt[d][j]) > $signed(mx)) mx = pkt[d][j];
        end
        fm = -1;
        fx = -1;
        for (int j = 0; j < n; j++) begin
            if (fm < 0 && pkt[d][j] == mn) fm = j;
            if (fx < 0 && pkt[d][j] == mx) fx = j;
        end
        expMin[d]    = mn;
        expMax[d]    = mx;
        expMinIdx[d] = (fm > maxCnt[d]) ? maxCnt[d] : fm;
        expMaxIdx[d] = (fx > maxCnt[d]) ? maxCnt[d] : fx;
        expCount[d]  = (n > maxCnt[d]) ? maxCnt[d] : n;
        expSat[d]    = (n > maxCnt[d]);
    endfunction

    // Model update on each clock edge: the block is ready exactly when no
    // result is pending, and a pending result leaves on out_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                expActive[d] = 1'b0;
                pktLen[d]    = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (expActive[d]) begin
                    if (outReady[d]) expActive[d] = 1'b0;
                end else if (inValid[d] && pktLen[d] < 256) begin
                    pkt[d][pktLen[d]] = inData[d];
                    pktLen[d]++;
                    if (inLast[d]) begin
                        modelResult(d);
                        expActive[d] = 1'b1;
                        pktLen[d]    = 0;
                    end
                end
            end
        end
    end

    task automatic compareDut(input int d, input logic ov, input logic ir,
                              input logic [31:0] mn, input logic [31:0] mx,
                              input logic [31:0] mnI, input logic [31:0] mxI,
                              input logic [31:0] cnt, input logic sat);
        string p;
        p = (d == 0) ? "A" : "B";
        checkOutput({p, ".out_valid"}, 32'(ov), 32'(expActive[d]));
        checkOutput({p, ".in_ready"}, 32'(ir), 32'(!expActive[d]));
        if (expActive[d]) begin
            checkOutput({p, ".out_min"}, mn, expMin[d]);
            checkOutput({p, ".out_max"}, mx, expMax[d]);
            checkOutput({p, ".out_min_idx"}, mnI, 32'(expMinIdx[d]));
            checkOutput({p, ".out_max_idx"}, mxI, 32'(expMaxIdx[d]));
            checkOutput({p, ".out_count"}, cnt, 32'(expCount[d]));
            checkOutput({p, ".out_sat"}, 32'(sat), 32'(expSat[d]));
        end
    endtask

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        compareDut(0, aOutValid, aInReady, aMin, aMax, 32'(aMinIdx), 32'(aMaxIdx), 32'(aCount), aSat);
        compareDut(1, bOutValid, bInReady, bMin, bMax, 32'(bMinIdx), 32'(bMaxIdx), 32'(bCount), bSat);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample after an optional idle gap and hold it until taken.
    task automatic sendSample(input int d, input logic [31:0] data, input logic last, input int gap);
        logic rdy;
        logic ok;
        inValid[d] = 1'b0;
        for (int g = 0; g < gap; g++) begin
            inData[d] = $urandom;
            inLast[d] = 1'($urandom_range(1));
            tick();
        end
        inValid[d] = 1'b1;
        inData[d]  = data;
        inLast[d]  = last;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = (d == 0) ? aInReady : bInReady;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        inValid[d] = 1'b0;
        inLast[d]  = 1'b0;
        if (!ok) reportTimeout("sample accept");
    endtask

    // Send vec[0..n-1] as one packet; gapPct sets the chance of idle cycles.
    task automatic applyStimulus(input int d, input int n, input int gapPct);
        int gap;
        for (int j = 0; j < n; j++) begin
            gap = ($urandom_range(99) < gapPct) ? $urandom_range(3, 1) : 0;
            sendSample(d, vec[j], (j == n - 1), gap);
        end
    endtask

    // Wait (bounded) until the result is offered; returns just after a negedge.
    task automatic waitResult(input int d);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((d == 0) ? aOutValid : bOutValid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportTimeout("result wait");
    endtask

    task automatic acceptResult(input int d);
        @(posedge clk);
        #1;
        outReady[d] = 1'b1;
        tick();
        outReady[d] = 1'b0;
    endtask

    initial begin
        maxCnt[0] = 65535;
        maxCnt[1] = 15;
        for (int d = 0; d < 2; d++) begin
            inValid[d]   = 1'b0;
            inLast[d]    = 1'b0;
            outReady[d]  = 1'b0;
            inData[d]    = '0;
            expActive[d] = 1'b0;
            pktLen[d]    = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.in_ready", 32'(aInReady), 32'd1);
        checkOutput("reset.out_valid", 32'(aOutValid), 32'd0);
        checkOutput("reset.out_min", aMin, 32'd0);
        checkOutput("reset.out_count", 32'(aCount), 32'd0);
        checkOutput("reset.out_sat", 32'(aSat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] reset mid-stream");
        sendSample(0, 32'd10, 1'b0, 0);
        sendSample(0, 32'd20, 1'b0, 0);
        sendSample(0, 32'd30, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.out_valid", 32'(aOutValid), 32'd0);
        checkOutput("midrst.in_ready", 32'(aInReady), 32'd1);
        checkOutput("midrst.out_count", 32'(aCount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sendSample(0, 32'd7, 1'b1, 0);
        waitResult(0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("holdrst.out_valid", 32'(aOutValid), 32'd0);
        checkOutput("holdrst.in_ready", 32'(aInReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sendSample(0, 32'h0000_0005, 1'b1, 0);
        waitResult(0);
        checkOutput("single.min", aMin, 32'd5);
        checkOutput("single.max", aMax, 32'd5);
        checkOutput("single.count", 32'(aCount), 32'd1);
        checkOutput("single.min_idx", 32'(aMinIdx), 32'd0);
        checkOutput("single.max_idx", 32'(aMaxIdx), 32'd0);
        acceptResult(0);

        $display("[TB] sign boundary");
        vec[0] = 32'h7FFF_FFFF;
        vec[1] = 32'h8000_0000;
        vec[2] = 32'h0000_0000;
        applyStimulus(0, 3, 0);
        waitResult(0);
        checkOutput("sign.min", aMin, 32'h8000_0000);
        checkOutput("sign.min_idx", 32'(aMinIdx), 32'd1);
        checkOutput("sign.max", aMax, 32'h7FFF_FFFF);
        checkOutput("sign.max_idx", 32'(aMaxIdx), 32'd0);
        checkOutput("sign.count", 32'(aCount), 32'd3);
        acceptResult(0);

        $display("[TB] ties");
        vec[0] = 32'hFFFF_FFFD;
        vec[1] = 32'd7;
        vec[2] = 32'hFFFF_FFFD;
        vec[3] = 32'd7;
        applyStimulus(0, 4, 0);
        waitResult(0);
        checkOutput("ties.min", aMin, 32'hFFFF_FFFD);
        checkOutput("ties.min_idx", 32'(aMinIdx), 32'd0);
        checkOutput("ties.max", aMax, 32'd7);
        checkOutput("ties.max_idx", 32'(aMaxIdx), 32'd1);
        acceptResult(0);

        $display("[TB] backpressure");
        vec[0] = 32'd1;
        vec[1] = 32'd2;
        applyStimulus(0, 2, 0);
        waitResult(0);
        @(posedge clk);
        #1;
        inValid[0] = 1'b1;
        inData[0]  = 32'h55;
        inLast[0]  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bp.out_valid", 32'(aOutValid), 32'd1);
            checkOutput("bp.in_ready", 32'(aInReady), 32'd0);
            checkOutput("bp.max", aMax, 32'd2);
            checkOutput("bp.count", 32'(aCount), 32'd2);
        end
        @(posedge clk);
        #1;
        outReady[0] = 1'b1;
        tick();
        outReady[0] = 1'b0;
        @(negedge clk);
        checkOutput("bp.after.out_valid", 32'(aOutValid), 32'd0);
        checkOutput("bp.after.in_ready", 32'(aInReady), 32'd1);
        tick();
        inValid[0] = 1'b0;
        inLast[0]  = 1'b0;
        waitResult(0);
        checkOutput("bp.next.min", aMin, 32'h55);
        checkOutput("bp.next.count", 32'(aCount), 32'd1);
        acceptResult(0);

        $display("[TB] bubbles");
        for (int j = 0; j < 100; j++) vec[j] = $urandom;
        applyStimulus(0, 100, 50);
        waitResult(0);
        checkOutput("bubbles.count", 32'(aCount), 32'd100);
        checkOutput("bubbles.sat", 32'(aSat), 32'd0);
        acceptResult(0);

        $display("[TB] saturation");
        for (int j = 0; j < 20; j++) vec[j] = 32'(100 + j);
        vec[17] = 32'hFFFF_FFCE;
        applyStimulus(1, 20, 0);
        waitResult(1);
        checkOutput("sat.count", 32'(bCount), 32'd15);
        checkOutput("sat.sat", 32'(bSat), 32'd1);
        checkOutput("sat.min", bMin, 32'hFFFF_FFCE);
        checkOutput("sat.min_idx", 32'(bMinIdx), 32'd15);
        checkOutput("sat.max", bMax, 32'd119);
        checkOutput("sat.max_idx", 32'(bMaxIdx), 32'd15);
        acceptResult(1);

        $display("[TB] count at limit");
        for (int j = 0; j < 15; j++) vec[j] = 32'(50 - j);
        applyStimulus(1, 15, 0);
        waitResult(1);
        checkOutput("limit.count", 32'(bCount), 32'd15);
        checkOutput("limit.sat", 32'(bSat), 32'd0);
        checkOutput("limit.min_idx", 32'(bMinIdx), 32'd14);
        checkOutput("limit.max_idx", 32'(bMaxIdx), 32'd0);
        acceptResult(1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
